cache_controller: RTL

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// 4-way set-associative write-back cache controller with external data array.
// Tags, valid/dirty bits and per-set LRU ages live here; block data is off-chip.
module cache_controller #(
  parameter int BLOCK_SIZE    = 32,
  parameter int ASSOCIATIVITY = 4,
  parameter int SET_SIZE      = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_ready,
  output logic [5:0]                da_index,
  output logic [1:0]                da_way,
  input  logic [BLOCK_SIZE*8-1:0]   da_rdata,
  output logic                      da_we,
  output logic [BLOCK_SIZE*8-1:0]   da_wdata,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [31:0]               mem_addr,
  output logic [BLOCK_SIZE*8-1:0]   mem_wdata,
  input  logic [BLOCK_SIZE*8-1:0]   mem_rdata,
  input  logic                      mem_ack
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, next_state;

  logic [20:0] req_tag;
  logic [5:0]  req_index;
  logic [2:0]  req_word;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [1:0]  victim_q;

  logic [ASSOCIATIVITY-1:0] valid [SET_SIZE];
  logic [ASSOCIATIVITY-1:0] dirty [SET_SIZE];
  logic [1:0]               age   [SET_SIZE][ASSOCIATIVITY];
  logic [20:0]              tag_mem [SET_SIZE][ASSOCIATIVITY];

  logic [ASSOCIATIVITY-1:0] hit_vec;
  logic                     hit;
  logic [1:0]               hit_way;
  logic [1:0]               victim_c;
  logic                     found_invalid;
  logic                     unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr[1:0];

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int unsigned i = 0; i < ASSOCIATIVITY; i++) begin
      hit_vec[i] = valid[req_index][i] && (tag_mem[req_index][i] == req_tag);
      if (hit_vec[i]) hit_way = i[1:0];
    end
    hit = $onehot(hit_vec);
  end

  // Lowest invalid way wins; with a full set the oldest (age 3) way is evicted.
  always_comb begin
    victim_c      = '0;
    found_invalid = 1'b0;
    for (int unsigned i = 0; i < ASSOCIATIVITY; i++) begin
      if (!valid[req_index][i] && !found_invalid) begin
        victim_c      = i[1:0];
        found_invalid = 1'b1;
      end
    end
    if (!found_invalid) begin
      for (int unsigned i = 0; i < ASSOCIATIVITY; i++) begin
        if (age[req_index][i] == 2'd3) victim_c = i[1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cpu_req) next_state = COMPARE;
      COMPARE: begin
        if (hit)
          next_state = IDLE;
        else if (valid[req_index][victim_c] && dirty[req_index][victim_c])
          next_state = WRITEBACK;
        else
          next_state = ALLOCATE;
      end
      WRITEBACK: if (mem_ack) next_state = ALLOCATE;
      ALLOCATE:  if (mem_ack) next_state = COMPARE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    da_index  = req_index;
    da_way    = '0;
    da_we     = 1'b0;
    da_wdata  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      COMPARE: begin
        if (hit) begin
          da_way    = hit_way;
          cpu_ready = 1'b1;
          cpu_rdata = da_rdata[{req_word, 5'b00000} +: 32];
          if (req_we) begin
            da_we    = 1'b1;
            da_wdata = da_rdata;
            da_wdata[{req_word, 5'b00000} +: 32] = req_wdata;
          end
        end else begin
          da_way = victim_c;
        end
      end
      WRITEBACK: begin
        da_way    = victim_q;
        mem_write = 1'b1;
        mem_addr  = {tag_mem[req_index][victim_q], req_index, 5'b00000};
        mem_wdata = da_rdata;
      end
      ALLOCATE: begin
        da_way   = victim_q;
        mem_read = 1'b1;
        mem_addr = {req_tag, req_index, 5'b00000};
        if (mem_ack) begin
          da_we    = 1'b1;
          da_wdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_tag   <= '0;
      req_index <= '0;
      req_word  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      victim_q  <= '0;
      for (int unsigned s = 0; s < SET_SIZE; s++) begin
        valid[s] <= '0;
        dirty[s] <= '0;
        for (int unsigned w = 0; w < ASSOCIATIVITY; w++) age[s][w] <= w[1:0];
      end
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            req_tag   <= cpu_addr[31:11];
            req_index <= cpu_addr[10:5];
            req_word  <= cpu_addr[4:2];
            req_we    <= cpu_we;
            req_wdata <= cpu_wdata;
          end
        end
        COMPARE: begin
          if (hit) begin
            // Ages younger than the hit way shift up by one, keeping a permutation.
            for (int unsigned w = 0; w < ASSOCIATIVITY; w++) begin
              if (age[req_index][w] < age[req_index][hit_way])
                age[req_index][w] <= age[req_index][w] + 2'd1;
            end
            age[req_index][hit_way] <= '0;
            if (req_we) dirty[req_index][hit_way] <= 1'b1;
          end else begin
            victim_q <= victim_c;
          end
        end
        ALLOCATE: begin
          if (mem_ack) begin
            valid[req_index][victim_q] <= 1'b1;
            dirty[req_index][victim_q] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ALLOCATE && mem_ack) tag_mem[req_index][victim_q] <= req_tag;
  end

endmodule
